// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the memory arbiter, its address checker
//               and MemCtl: FSM state encoding, requester identifiers and
//               word-geometry helpers (WORD_BYTES, alignment mask).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    // Arbiter FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Requester identity (also used as round-robin history)
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    // Number of bytes in one memory word (WORD_BYTES)
    function automatic int unsigned word_bytes(input int unsigned data_width,
                                               input int unsigned byte_width);
        return data_width / byte_width;
    endfunction

    // Low-order byte-address bits that must be zero for an aligned word
    function automatic int unsigned align_mask(input int unsigned data_width,
                                               input int unsigned byte_width);
        return word_bytes(data_width, byte_width) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_addr_check.sv
// ============================================================================
// Module      : mem_addr_check
// Description : Combinational access-fault detector. Flags a byte address
//               that is not word aligned or whose word does not lie fully
//               inside the 0..SIZE-1 window.
// Ports       : i_addr  byte address under test
//               o_err   1 = misaligned or out of range
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_addr_check
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int SIZE       = 256
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_err
);

    localparam int unsigned c_WORD_BYTES = word_bytes(DATA_WIDTH, BYTE_WIDTH);

    localparam logic [ADDR_WIDTH-1:0] c_MASK =
        ADDR_WIDTH'(align_mask(DATA_WIDTH, BYTE_WIDTH));

    // Highest byte address at which a whole word still fits
    localparam logic [ADDR_WIDTH-1:0] c_LAST_WORD =
        ADDR_WIDTH'(SIZE - int'(c_WORD_BYTES));

    logic w_misaligned;
    logic w_out_of_range;

    assign w_misaligned   = (i_addr & c_MASK) != '0;
    assign w_out_of_range = i_addr > c_LAST_WORD;
    assign o_err          = w_misaligned | w_out_of_range;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter/sequencer sharing one MemCtl between the
//               instruction-fetch port (read only) and the load/store port.
//               A granted access holds mem_op for MEM_LATENCY cycles, then
//               samples mem_data_r and pulses the owner's ack for one cycle.
//               Misaligned or out-of-range accesses are answered locally with
//               err=1 and never reach MemCtl.
// Ports       : sys_clk, sys_rst (sync, active-low)
//               if_req/if_addr -> if_ack/if_rdata/if_err
//               ls_req/ls_we/ls_addr/ls_wdata -> ls_ack/ls_rdata/ls_err
//               mem_op/mem_rw/mem_addr/mem_data_w -> MemCtl, mem_data_r <-
//               busy : FSM not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BYTE_WIDTH  = 8,
    parameter int SIZE        = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    // instruction-fetch port
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,
    // load/store port
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_ack,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ls_err,
    // MemCtl side
    output logic                  mem_op,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_w,
    input  logic [DATA_WIDTH-1:0] mem_data_r,
    // status
    output logic                  busy
);

    // Counter wide enough to hold MEM_LATENCY-1 (at least one bit)
    localparam int c_CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LATENCY - 1);

    state_t                r_state;
    state_t                w_next_state;
    owner_t                r_owner;
    owner_t                r_rr_last;
    logic                  r_rw;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_ls_rdata;
    logic                  r_if_err;
    logic                  r_ls_err;

    logic                  w_gnt_if;
    logic                  w_gnt_ls;
    logic                  w_grant;
    logic [ADDR_WIDTH-1:0] w_gnt_addr;
    logic                  w_addr_err;
    logic                  w_cnt_zero;

    // ------------------------------------------------------------------------
    // Arbitration: on a tie the port that was not served last wins.
    // ------------------------------------------------------------------------
    assign w_gnt_if   = if_req && (!ls_req || (r_rr_last == OWN_LS));
    assign w_gnt_ls   = ls_req && !w_gnt_if;
    assign w_grant    = w_gnt_if | w_gnt_ls;
    assign w_gnt_addr = w_gnt_ls ? ls_addr : if_addr;
    assign w_cnt_zero = (r_cnt == '0);

    // The winner's address is checked before it is registered so a faulting
    // access goes straight to DONE and MemCtl never sees it.
    mem_addr_check #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .SIZE       (SIZE)
    ) u_addr_check (
        .i_addr (w_gnt_addr),
        .o_err  (w_addr_err)
    );

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        mem_op       = 1'b0;
        mem_rw       = 1'b0;
        mem_addr     = '0;
        mem_data_w   = '0;
        if_ack       = 1'b0;
        ls_ack       = 1'b0;
        busy         = 1'b1;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_grant) begin
                    w_next_state = w_addr_err ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_op     = 1'b1;
                mem_rw     = r_rw;
                mem_addr   = r_addr;
                mem_data_w = r_wdata;
                if (w_cnt_zero) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if_ack       = (r_owner == OWN_IF);
                ls_ack       = (r_owner == OWN_LS);
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Per-port result registers hold their value between acks
    assign if_rdata = r_if_rdata;
    assign if_err   = r_if_err;
    assign ls_rdata = r_ls_rdata;
    assign ls_err   = r_ls_err;

    // ------------------------------------------------------------------------
    // Datapath: request capture, latency counter, read-data capture
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_owner    <= OWN_IF;
            r_rr_last  <= OWN_LS;   // first tie goes to the fetch port
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
            r_if_err   <= 1'b0;
            r_ls_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner   <= w_gnt_ls ? OWN_LS : OWN_IF;
                        r_rr_last <= w_gnt_ls ? OWN_LS : OWN_IF;
                        r_rw      <= w_gnt_ls & ls_we;
                        r_addr    <= w_gnt_addr;
                        r_wdata   <= w_gnt_ls ? ls_wdata : '0;
                        r_cnt     <= c_CNT_LOAD;
                        if (w_gnt_ls) begin
                            r_ls_err <= w_addr_err;
                            // stores (faulting or not) return zero data
                            if (ls_we) begin
                                r_ls_rdata <= '0;
                            end
                        end else begin
                            r_if_err <= w_addr_err;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_cnt_zero) begin
                        if (!r_rw) begin
                            if (r_owner == OWN_LS) begin
                                r_ls_rdata <= mem_data_r;
                            end else begin
                                r_if_rdata <= mem_data_r;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter and sequencer that shares the single MemCtl instance between the core's instruction-fetch port (read-only) and its load/store port (read/write). It accepts req/ack transactions from both requesters and picks a winner by round-robin. It drives MemCtl's op/rw/addr/data_w for a fixed number of cycles and returns data_r to the winning requester. Misaligned and out-of-range accesses are trapped locally and never reach MemCtl.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data word width
BYTE_WIDTH, 8, bits per byte; word stride is DATA_WIDTH/BYTE_WIDTH
SIZE, 256, memory size in bytes; legal addresses are 0..SIZE-1
MEM_LATENCY, 2, cycles op is held asserted before data_r is sampled (>=1)

Ports:
sys_clk  in  1  clock, rising edge
sys_rst  in  1  synchronous reset, active-low
if_req  in  1  fetch request; held with if_addr until if_ack
if_addr  in  ADDR_WIDTH  fetch byte address
if_ack  out  1  one-cycle completion pulse
if_rdata  out  DATA_WIDTH  fetch data, valid while if_ack=1
if_err  out  1  access fault, valid while if_ack=1
ls_req  in  1  load/store request; held with ls_we/ls_addr/ls_wdata until ls_ack
ls_we  in  1  1=store, 0=load
ls_addr  in  ADDR_WIDTH  load/store byte address
ls_wdata  in  DATA_WIDTH  store data
ls_ack  out  1  one-cycle completion pulse
ls_rdata  out  DATA_WIDTH  load data, valid while ls_ack=1 and ls_we=0
ls_err  out  1  access fault, valid while ls_ack=1
mem_op  out  1  to MemCtl op
mem_rw  out  1  to MemCtl rw (1=write)
mem_addr  out  ADDR_WIDTH  to MemCtl addr
mem_data_w  out  DATA_WIDTH  to MemCtl data_w
mem_data_r  in  DATA_WIDTH  from MemCtl data_r
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (sys_rst=0 at a rising edge): state=IDLE; every output is 0; rr_last=LS, so the first tie goes to IF. Reset mid-access aborts the access: mem_op=0 in the following cycle and no ack is issued.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that requester.
  - Both reqs: grant the requester that is not rr_last.
  - On grant, register owner, rw, addr and wdata, and update rr_last.
  - If the registered addr is invalid, go to DONE with err=1. Invalid means addr[log2(DATA_WIDTH/BYTE_WIDTH)-1:0] != 0 or addr > SIZE-(DATA_WIDTH/BYTE_WIDTH).
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_op=1, with mem_rw/mem_addr/mem_data_w taken from the registered values and stable.
  - A down-counter loaded with MEM_LATENCY-1 counts to 0.
  - On count=0, capture mem_data_r into the rdata register (loads and fetches only) and go to DONE.
- DONE:
  - mem_op=0.
  - The owner's ack=1 for exactly one cycle, with rdata/err valid. The other ack stays 0.
  - Next state is IDLE.
- Timing:
  - Valid req high in IDLE in cycle 0 gives mem_op=1 in cycles 1..MEM_LATENCY and ack in cycle MEM_LATENCY+1.
  - Faulting req gives ack+err in cycle 1.
  - Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Requesters:
  - A requester must drop req in the cycle after ack. A req still high in IDLE is taken as a new transaction.
  - Requests are sampled only in IDLE. req changes during ACCESS or DONE are ignored.
- Stores: ls_rdata=0 on ack. A faulting store never asserts mem_op.
- Round-robin guarantees a continuously requesting port waits at most one other transaction.
- rdata/err hold their last value between acks. Consumers only read them while ack=1.

Decomposition:
- Shared package mem_pkg holds:
  - state encoding constants ST_IDLE/ST_ACCESS/ST_DONE;
  - owner constants OWN_IF/OWN_LS;
  - the WORD_BYTES and alignment-mask helper constant, shared with MemCtl.
- A sub-module is not required. The address checker mem_addr_check (combinational: addr -> err) is factored out because the LSU reuses it.

Test Plan (MEM_LATENCY=2, SIZE=256, MemCtl instantiated behind the arbiter):
1. Release reset, then ls_req store ls_addr=0x10, ls_wdata=0xDEADBEEF -> mem_op=1, rw=1 for 2 cycles. ls_ack in cycle 3 with ls_err=0. A later if_req to if_addr=0x10 gives if_rdata=0xDEADBEEF.
2. if_req and ls_req (load 0x10) rise in the same cycle after reset -> IF is served first (if_ack in cycle 3) and LS second (ls_ack in cycle 7). Both keep requesting -> grants alternate IF, LS, IF, LS.
3. ls_req load at ls_addr=0x12 (misaligned) -> ls_ack with ls_err=1 in cycle 1 and mem_op never asserted. if_addr=0xFC is legal: err=0. if_addr=0x100 gives if_err=1.
4. ls_req store 0x20 value 0x5; sys_rst=0 in the first ACCESS cycle -> mem_op=0 and busy=0 next cycle, no ls_ack. Reading 0x20 after release returns whatever the MemCtl array holds, and the bench checks the arbiter never acks.
5. Batch: stores i to addr 4*i for i=0..7, then loads via if_req -> each if_rdata==i. Each ack is exactly one cycle wide and the spacing between accesses is 4 cycles.
6. if_req held high through its ack cycle -> a second fetch starts in the following IDLE cycle, and exactly two acks are issued.
